// File: rtl/hpram_arb_pkg.sv
// Shared types and helpers for the HyperRAM command arbiter.
package hpram_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrPull,
    StWrData,
    StRdCmd,
    StRdWait,
    StGap
  } arb_state_e;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((longint'(1) << result) < longint'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hpram_cmd_arbiter.sv
// Round-robin arbiter sharing the HyperRAM command/data port between the write and read DMAs.
// One fixed-length burst at a time, followed by an enforced idle gap.
module hpram_cmd_arbiter
  import hpram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 22,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BURST_BEATS = 4,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned RD_TIMEOUT  = 255
) (
  input  logic                    I_dma_clk,
  input  logic                    I_rst_n,
  input  logic                    I_init_calib,
  input  logic                    I_wr_req,
  input  logic [ADDR_WIDTH-1:0]   I_wr_addr,
  output logic                    O_wr_ack,
  output logic                    O_wr_data_rd,
  input  logic [DATA_WIDTH-1:0]   I_wr_data,
  input  logic [DATA_WIDTH/8-1:0] I_wr_mask,
  input  logic                    I_rd_req,
  input  logic [ADDR_WIDTH-1:0]   I_rd_addr,
  output logic                    O_rd_ack,
  output logic                    O_rd_valid,
  output logic [DATA_WIDTH-1:0]   O_rd_data,
  output logic                    O_rd_done,
  output logic                    O_cmd,
  output logic                    O_cmd_en,
  output logic [ADDR_WIDTH-1:0]   O_addr,
  output logic [DATA_WIDTH-1:0]   O_wr_data,
  output logic [DATA_WIDTH/8-1:0] O_data_mask,
  input  logic                    I_rd_data_valid,
  input  logic [DATA_WIDTH-1:0]   I_rd_data,
  output logic                    O_busy,
  output logic                    O_rd_timeout
);

  localparam int unsigned MaskW = DATA_WIDTH / 8;
  localparam int unsigned BeatW = clog2(BURST_BEATS + 1);
  localparam int unsigned WaitW = clog2(RD_TIMEOUT + 1);
  localparam int unsigned GapW  = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;

  localparam logic [BeatW-1:0] BeatOne   = BeatW'(1);
  localparam logic [BeatW-1:0] BeatsAll  = BeatW'(BURST_BEATS);
  localparam logic [BeatW-1:0] BeatsLast = BeatW'(BURST_BEATS - 1);
  localparam logic [WaitW-1:0] WaitOne   = WaitW'(1);
  localparam logic [WaitW-1:0] WaitLast  = WaitW'(RD_TIMEOUT - 1);
  localparam logic [GapW-1:0]  GapOne    = GapW'(1);
  localparam logic [GapW-1:0]  GapLast   = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // With no gap configured a finished burst returns straight to idle.
  localparam arb_state_e StAfter = (GAP_CYCLES == 0) ? StIdle : StGap;

  arb_state_e             state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic [BeatW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;

  logic                   cmd_q, cmd_d;
  logic                   cmd_en_q, cmd_en_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [MaskW-1:0]       data_mask_q, data_mask_d;
  logic                   wr_ack_q, wr_ack_d;
  logic                   rd_ack_q, rd_ack_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   rd_done_q, rd_done_d;
  logic                   rd_timeout_q, rd_timeout_d;

  logic                   wr_data_rd;
  logic                   grant_wr, grant_rd;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    data_mask_d  = data_mask_q;
    rd_data_d    = rd_data_q;
    rd_timeout_d = rd_timeout_q;
    cmd_en_d     = 1'b0;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;
    rd_valid_d   = 1'b0;
    rd_done_d    = 1'b0;
    wr_data_rd   = 1'b0;

    // On a tie the side not served last wins.
    if (I_wr_req && I_rd_req) begin
      grant_wr = (last_grant_q == CMD_RD);
      grant_rd = (last_grant_q == CMD_WR);
    end else begin
      grant_wr = I_wr_req;
      grant_rd = I_rd_req;
    end

    unique case (state_q)
      StIdle: begin
        if (I_init_calib && grant_rd) begin
          state_d      = StRdCmd;
          last_grant_d = CMD_RD;
          cmd_en_d     = 1'b1;
          rd_ack_d     = 1'b1;
          cmd_d        = CMD_RD;
          addr_d       = I_rd_addr;
        end else if (I_init_calib && grant_wr) begin
          state_d      = StWrPull;
          last_grant_d = CMD_WR;
          cmd_d        = CMD_WR;
          addr_d       = I_wr_addr;
        end
      end
      StWrPull: begin
        wr_data_rd  = 1'b1;
        wr_data_d   = I_wr_data;
        data_mask_d = I_wr_mask;
        cmd_en_d    = 1'b1;
        wr_ack_d    = 1'b1;
        beat_cnt_d  = BeatOne;
        state_d     = StWrData;
      end
      StWrData: begin
        if (beat_cnt_q == BeatsAll) begin
          state_d   = StAfter;
          gap_cnt_d = '0;
        end else begin
          wr_data_rd  = 1'b1;
          wr_data_d   = I_wr_data;
          data_mask_d = I_wr_mask;
          beat_cnt_d  = beat_cnt_q + BeatOne;
        end
      end
      StRdCmd: begin
        state_d    = StRdWait;
        beat_cnt_d = '0;
        wait_cnt_d = '0;
      end
      StRdWait: begin
        wait_cnt_d = wait_cnt_q + WaitOne;
        if (I_rd_data_valid) begin
          rd_valid_d = 1'b1;
          rd_data_d  = I_rd_data;
          beat_cnt_d = beat_cnt_q + BeatOne;
        end
        // A final beat arriving on the timeout cycle still counts as a normal finish.
        if (I_rd_data_valid && beat_cnt_q == BeatsLast) begin
          rd_done_d = 1'b1;
          state_d   = StAfter;
          gap_cnt_d = '0;
        end else if (wait_cnt_q == WaitLast) begin
          rd_done_d    = 1'b1;
          rd_timeout_d = 1'b1;
          state_d      = StAfter;
          gap_cnt_d    = '0;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= CMD_WR;
      beat_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      cmd_q        <= 1'b0;
      cmd_en_q     <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      data_mask_q  <= '0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_done_q    <= 1'b0;
      rd_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cmd_q        <= cmd_d;
      cmd_en_q     <= cmd_en_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      data_mask_q  <= data_mask_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_done_q    <= rd_done_d;
      rd_timeout_q <= rd_timeout_d;
    end
  end

  assign O_wr_ack     = wr_ack_q;
  assign O_wr_data_rd = wr_data_rd;
  assign O_rd_ack     = rd_ack_q;
  assign O_rd_valid   = rd_valid_q;
  assign O_rd_data    = rd_data_q;
  assign O_rd_done    = rd_done_q;
  assign O_cmd        = cmd_q;
  assign O_cmd_en     = cmd_en_q;
  assign O_addr       = addr_q;
  assign O_wr_data    = wr_data_q;
  assign O_data_mask  = data_mask_q;
  assign O_busy       = (state_q != StIdle);
  assign O_rd_timeout = rd_timeout_q;

endmodule

// File: doc/hpram_cmd_arbiter.md
# hpram_cmd_arbiter

Two-port command arbiter sharing the single HyperRAM memory-interface command/data port between the frame-buffer write DMA (camera or test-pattern input side) and the read DMA (HDMI output side). It grants one fixed-length burst at a time with round-robin fairness and drives `cmd`/`cmd_en`/`addr`/`wr_data`/`data_mask`. It collects `rd_data_valid` beats back to the read requester and enforces an inter-command gap. It sits in the `dma_clk` domain between the frame-buffer DMA logic and the HyperRAM memory interface.

## Interface
- `ADDR_WIDTH`, 22, memory word address width
- `DATA_WIDTH`, 32, memory data width; mask width = DATA_WIDTH/8
- `BURST_BEATS`, 4, data beats per write or read burst (≥1)
- `GAP_CYCLES`, 8, idle cycles enforced after every burst (0 allowed)
- `RD_TIMEOUT`, 255, max cycles waited in RD_WAIT for all read beats

- `I_dma_clk` in 1: sole clock (memory-interface `clk_out`)
- `I_rst_n` in 1: reset; one clock, asynchronous active-low reset
- `I_init_calib` in 1: memory calibrated; no grant while low
- `I_wr_req` / `I_wr_addr` in 1 / ADDR_WIDTH: write burst request and start address (held until ack)
- `O_wr_ack` out 1: one-cycle pulse, write command accepted
- `O_wr_data_rd` out 1: pull strobe to show-ahead write FIFO
- `I_wr_data` / `I_wr_mask` in DATA_WIDTH / DATA_WIDTH/8: write beat and mask, valid during `O_wr_data_rd`
- `I_rd_req` / `I_rd_addr` in 1 / ADDR_WIDTH: read burst request and address (held until ack)
- `O_rd_ack` out 1: one-cycle pulse, read command issued
- `O_rd_valid` / `O_rd_data` out 1 / DATA_WIDTH: returned read beat
- `O_rd_done` out 1: one-cycle pulse, read burst finished (normal or timeout)
- `O_cmd` out 1: 1 = write, 0 = read
- `O_cmd_en` out 1: command strobe
- `O_addr` out ADDR_WIDTH: command address
- `O_wr_data` / `O_data_mask` out DATA_WIDTH / DATA_WIDTH/8: write beat to memory
- `I_rd_data_valid` / `I_rd_data` in 1 / DATA_WIDTH: read beats from memory
- `O_busy` out 1: state ≠ IDLE
- `O_rd_timeout` out 1: sticky, set on any read timeout, cleared only by reset

## Operation
- States: IDLE, WR_PULL, WR_DATA, RD_CMD, RD_WAIT, GAP.
- IDLE: if `I_init_calib`=1 and a request is present, grant it. If both request, grant the one not granted last. `last_grant` resets to write, so read wins the first tie.
- Write grant: IDLE→WR_PULL. `O_wr_data_rd`=1 for BURST_BEATS consecutive cycles starting in WR_PULL; each pulled beat/mask is registered onto `O_wr_data`/`O_data_mask` one cycle later.
- The first registered beat coincides with `O_cmd_en`=1, `O_cmd`=1, `O_addr`=latched `I_wr_addr`, and `O_wr_ack`=1.
- Beats continue on consecutive cycles (WR_DATA). After the last beat → GAP.
- Read grant: IDLE→RD_CMD. This is a single cycle with `O_cmd_en`=1, `O_cmd`=0, `O_addr`=`I_rd_addr`, `O_rd_ack`=1; then → RD_WAIT.
- RD_WAIT: each `I_rd_data_valid` is forwarded as `O_rd_valid`/`O_rd_data` registered one cycle later, and a beat counter (width clog2(BURST_BEATS+1)) counts it.
  - On the BURST_BEATS-th beat → GAP; `O_rd_done` is coincident with the last `O_rd_valid`.
  - If the wait counter reaches RD_TIMEOUT first → GAP; `O_rd_done` pulses and `O_rd_timeout` is set. Beats received so far stay delivered.
- `I_rd_data_valid` outside RD_WAIT is ignored and not forwarded.
- GAP: counts GAP_CYCLES then → IDLE; GAP_CYCLES=0 means direct → IDLE.
- `I_init_calib` falling mid-burst: the current burst completes normally, and no further grants are made until it rises.

## Timing
- All outputs reset to 0; state resets to IDLE, counters to 0, `last_grant` to write.
- Reset asserted mid-burst aborts immediately. No partial `O_cmd_en` may follow reset release.
- Grant decision is registered. A request seen in IDLE at edge t gives:
  - `O_rd_ack`/`O_cmd_en` at t+1 for a read;
  - `O_wr_data_rd` at t+1 and `O_cmd_en`/`O_wr_ack` at t+2 for a write.
- Write occupancy is BURST_BEATS+1 cycles, then GAP_CYCLES.
- At most one `O_cmd_en` per burst. Minimum spacing between `O_cmd_en` pulses is GAP_CYCLES+1 or more.
- Requesters may change address only after their ack. A request deasserted before ack is simply not granted.

## Structure
- Shared package `hpram_arb_pkg`: state enum, `CMD_WR`=1'b1, `CMD_RD`=1'b0, and the clog2 helper.
- No sub-module. The 2-way round-robin picker is a few lines inside the FSM.

## Test plan
- `I_init_calib`=0 with both requests held for 100 cycles → no `O_cmd_en`. Raise calib → read granted first (`O_cmd`=0), then write.
- Single write at addr 0x000100, FIFO beats 0xA0..0xA3 → `O_cmd_en`/`O_cmd`=1/`O_addr`=0x100 with 0xA0, then 0xA1–0xA3 on the next three cycles; `O_wr_data_rd` high exactly 4 cycles, one cycle earlier.
- Read at 0x000200, model returns 4 valid beats with gaps → 4 `O_rd_valid`, each 1 cycle late, with `O_rd_done` on the 4th. The next `O_cmd_en` is no earlier than 9 cycles after the read `O_cmd_en`, plus the return time.
- Both requesters continuously asserted for 20 bursts → strictly alternating RD/WR grants, 10 each.
- Read model returns 2 beats only → after 255 cycles in RD_WAIT, `O_rd_done` pulses and `O_rd_timeout`=1 and stays set. A stray valid afterwards is not forwarded.
- `I_rst_n` pulsed low during WR_DATA → all outputs 0 asynchronously. After release, a new request is served from IDLE normally.
